note_scheduler: RTL
===================

NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter SUSTAIN_CYCLES, default 6_250_000: clocks a note sounds (250 ms at 25 MHz).
REQ-002 Parameter GAP_CYCLES, default 250_000: silent clocks between queued notes (10 ms).
REQ-003 Parameter DEPTH, default 4: strum queue entries, power of two, minimum 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 strum_edge  input  1  one-cycle pulse from the strum input conditioner (either edge).
REQ-007 note_sel  input  7  note switches, one-hot; bit 6 = A, bit 0 = G.
REQ-008 flush  input  1  synchronous abort: discard queue and silence.
REQ-009 note_code  output  3  note select to the frequency generator: A=0 ... G=6.
REQ-010 tone_en  output  1  gate for the frequency generator output; 1 only while playing.
REQ-011 busy  output  1  high when state is not IDLE.
REQ-012 queue_count  output  $clog2(DEPTH)+1  entries currently queued.
REQ-013 dropped  output  1  one-cycle pulse when a strum is lost to a full queue.

Function
REQ-014 On strum_edge, note_sel SHALL be encoded: bit6->0, bit5->1, bit4->2, bit3->3, bit2->4, bit1->5, bit0->6; any non-one-hot value (zero or multiple bits set) SHALL encode to 6 (G).
REQ-015 The encoded code SHALL be pushed into a FIFO at the same edge the pulse is sampled; queue_count increments after that edge.
REQ-016 FSM states SHALL be exactly IDLE, PLAY, GAP.
REQ-017 IDLE: if queue non-empty, pop the head, load note_code, load the timer with SUSTAIN_CYCLES-1, and go to PLAY; otherwise stay.
REQ-018 PLAY: tone_en=1; decrement the timer; at 0, load the timer with GAP_CYCLES-1 and go to GAP.
REQ-019 GAP: tone_en=0; decrement the timer; at 0, go to PLAY with a pop if the queue is non-empty, else go to IDLE.
REQ-020 A note SHALL sound for exactly SUSTAIN_CYCLES clocks, and the gap SHALL be exactly GAP_CYCLES clocks.
REQ-021 Latency: a strum sampled at edge N into an empty queue while IDLE SHALL give tone_en=1 and a valid note_code after edge N+1.
REQ-022 note_code SHALL hold its last value outside PLAY; it changes only on a pop.
REQ-023 Push to a full queue without a simultaneous pop SHALL be discarded, with dropped=1 for one cycle; the queue is unchanged.
REQ-024 Simultaneous push and pop SHALL both take effect, including when the queue is full; queue_count is unchanged.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; queue_count SHALL saturate at neither bound incorrectly (range 0..DEPTH).
REQ-026 flush SHALL clear the queue and return to IDLE with tone_en=0 after the edge; it has priority over a simultaneous strum, which is discarded with no dropped pulse.
REQ-027 The timer width SHALL be $clog2(max(SUSTAIN_CYCLES,GAP_CYCLES)) bits with no overflow.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, queue empty, queue_count=0, note_code=0, tone_en=0, busy=0, dropped=0, timer=0.
REQ-029 Reset asserted mid-note SHALL silence tone_en without waiting for a clock; the first strum after release behaves as in REQ-021.

Structure
REQ-030 Shared package guitar_pkg SHALL hold the note-code constants A..G (0..6), the default note G, the state enumeration, and the one-hot-to-code encode function.
REQ-031 The queue SHALL be the sub-module note_fifo (DEPTH x 3 bits, push/pop/full/empty/count, async active-low reset); the FSM and timer stay in note_scheduler.

Verification (bench parameters: SUSTAIN_CYCLES=8, GAP_CYCLES=2, DEPTH=4)
REQ-032 Strum with note_sel=7'b0001000 while IDLE -> note_code=3 and tone_en=1 after edge N+1; tone_en high for 8 clocks, then 2 low clocks, then IDLE with busy=0.
REQ-033 Strum with note_sel=0 and again with 7'b0100100 -> both encode to note_code=6.
REQ-034 Six strums on consecutive cycles during PLAY with codes 0,1,2,3,4,5 -> 4 queued, dropped pulses on the 5th and 6th, playback order 0,1,2,3, each separated by a 2-clock gap.
REQ-035 Queue full, and a strum arrives on the GAP->PLAY pop edge -> accepted, queue_count stays 4, dropped=0.
REQ-036 flush and strum in the same cycle during PLAY with 3 queued -> next cycle IDLE, tone_en=0, queue_count=0, dropped=0.
REQ-037 rst_n asserted between clock edges mid-PLAY -> tone_en=0 and note_code=0 immediately; after release a strum replays per REQ-021.

Source files
------------

// File: rtl/guitar_pkg.sv
// Shared definitions for the strum-driven note scheduler: note codes,
// scheduler states and the note-switch encoder.
package guitar_pkg;

    localparam logic [2:0] NOTE_A       = 3'd0;
    localparam logic [2:0] NOTE_B       = 3'd1;
    localparam logic [2:0] NOTE_C       = 3'd2;
    localparam logic [2:0] NOTE_D       = 3'd3;
    localparam logic [2:0] NOTE_E       = 3'd4;
    localparam logic [2:0] NOTE_F       = 3'd5;
    localparam logic [2:0] NOTE_G       = 3'd6;
    localparam logic [2:0] NOTE_DEFAULT = NOTE_G;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One-hot switch vector (bit 6 = A .. bit 0 = G) to note code.
    // Anything that is not exactly one-hot falls back to G.
    function automatic logic [2:0] encode_note(input logic [6:0] sel);
        logic [2:0] code;
        case (sel)
            7'b1000000: code = NOTE_A;
            7'b0100000: code = NOTE_B;
            7'b0010000: code = NOTE_C;
            7'b0001000: code = NOTE_D;
            7'b0000100: code = NOTE_E;
            7'b0000010: code = NOTE_F;
            7'b0000001: code = NOTE_G;
            default:    code = NOTE_DEFAULT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Small synchronous FIFO holding queued note codes. A push is accepted
// when there is room or when a pop happens on the same edge; clear wins
// over both and empties the queue.
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage; pointers wrap since DEPTH is a power of two.
    always_comb begin
        pop_ok   = pop && !empty && !clear;
        push_ok  = push && !clear && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/note_scheduler.sv
// Strum-driven note scheduler: queues encoded notes and plays each one
// for SUSTAIN_CYCLES clocks, separated by GAP_CYCLES silent clocks.
module note_scheduler
    import guitar_pkg::*;
#(
    parameter int SUSTAIN_CYCLES = 6_250_000,
    parameter int GAP_CYCLES     = 250_000,
    parameter int DEPTH          = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   strum_edge,
    input  logic [6:0]             note_sel,
    input  logic                   flush,
    output logic [2:0]             note_code,
    output logic                   tone_en,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   dropped
);

    localparam int MAX_CYC   = (SUSTAIN_CYCLES > GAP_CYCLES) ? SUSTAIN_CYCLES : GAP_CYCLES;
    localparam int TIMER_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam logic [TIMER_W-1:0] SUSTAIN_LOAD = TIMER_W'(SUSTAIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           note_code_q, note_code_d;
    logic                 dropped_q, dropped_d;
    logic                 pop;
    logic                 push;
    logic [2:0]           head_code;
    logic                 fifo_full;
    logic                 fifo_empty;

    // A flush discards any strum arriving with it.
    assign push = strum_edge && !flush;

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (encode_note(note_sel)),
        .dout  (head_code),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    assign note_code = note_code_q;
    assign tone_en   = (state_q == ST_PLAY);
    assign busy      = (state_q != ST_IDLE);
    assign dropped   = dropped_q;

    // Next state, timer, pop decision and drop detection.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        note_code_d = note_code_q;
        pop         = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        note_code_d = head_code;
                        timer_d     = SUSTAIN_LOAD;
                        state_d     = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (timer_q == '0) begin
                        timer_d = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_GAP: begin
                    if (timer_q == '0) begin
                        if (!fifo_empty) begin
                            pop         = 1'b1;
                            note_code_d = head_code;
                            timer_d     = SUSTAIN_LOAD;
                            state_d     = ST_PLAY;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
        // A pop on the same edge makes room, so only a full queue without pop drops.
        dropped_d = push && fifo_full && !pop;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            note_code_q <= NOTE_A;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            note_code_q <= note_code_d;
            dropped_q   <= dropped_d;
        end
    end

endmodule
